// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: types and constants shared by the pipeline front end.
// IF_MISALIGN_TRAP_EN adds the TRAP fetch state.
`default_nettype none

package rv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

`ifdef IF_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/pc_register.sv
// pc_register: 32-bit program counter with synchronous reset and load enable.
`default_nettype none

module pc_register #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC sequencing, stall/redirect handling and fetch counting.
// Optional macro IF_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
`default_nettype none

module if_fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        LE,
  input  logic        Redirect_IN,
  input  logic [31:0] Target_IN,
  input  logic [31:0] Instr_Mem_DATA,
  output logic [31:0] Instr_Mem_ADDR,
  output logic [31:0] Instruction_OUT,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC4_OUT,
  output logic        Valid_OUT,
  output logic        IF_ID_LE_OUT,
  output logic        Flush_OUT,
  output logic [31:0] Fetch_Count_OUT,
  output logic        Misalign_OUT
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4;
  logic         pc_load;
  logic         valid;
  logic         misalign_set;
  logic [31:0]  fetch_count;

  pc_register #(.RESET_VAL(RESET_PC)) u_pc (
    .clk  (clk),
    .rst  (Reset),
    .load (pc_load),
    .d    (pc_next),
    .q    (pc)
  );

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pc_load      = 1'b0;
    valid        = 1'b0;
    misalign_set = 1'b0;
    if (state == ST_BOOT) begin
      state_next = ST_RUN;
    end else if (Redirect_IN) begin
      // Redirect beats stall and normal advance; the wrong-path word is dropped.
      pc_load = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
      if (Target_IN[1:0] != 2'b00) begin
        pc_next      = TRAP_PC;
        state_next   = ST_TRAP;
        misalign_set = 1'b1;
      end else begin
        pc_next    = Target_IN;
        state_next = ST_RUN;
      end
`else
      pc_next    = {Target_IN[31:2], 2'b00};
      state_next = ST_RUN;
`endif
    end else begin
      case (state)
        ST_RUN, ST_STALL: begin
          if (LE) begin
            valid      = 1'b1;
            pc_load    = 1'b1;
            pc_next    = pc_plus4;
            state_next = ST_RUN;
          end else begin
            state_next = ST_STALL;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      fetch_count <= 32'd0;
    end else if (valid) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign;

  always_ff @(posedge clk) begin
    if (Reset) begin
      misalign <= 1'b0;
    end else if (misalign_set) begin
      misalign <= 1'b1;
    end
  end

  assign Misalign_OUT = misalign;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{Target_IN[1:0], TRAP_PC, misalign_set};
  assign Misalign_OUT = 1'b0;
`endif

  assign Instr_Mem_ADDR  = pc;
  assign Instruction_OUT = valid ? Instr_Mem_DATA : NOP_INSTR;
  assign PC_OUT          = pc;
  assign PC4_OUT         = pc_plus4;
  assign Valid_OUT       = valid;
  assign IF_ID_LE_OUT    = LE & ~Redirect_IN;
  assign Flush_OUT       = Redirect_IN;
  assign Fetch_Count_OUT = fetch_count;

endmodule

`default_nettype wire

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the RISC-V pipeline, directly upstream of the IF/ID pipeline register. It holds the program counter and drives the instruction-memory address. It forwards the fetched word, PC and PC+4 to IF/ID, and handles stalls and EX-stage redirects, flushing IF/ID on a redirect. It also keeps a count of delivered instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on Reset.
- TRAP_PC, 32'h0000_0100, PC loaded on a misaligned redirect (used only when the Configuration macro is compiled in).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- LE  input  1  fetch advance enable from the hazard unit; 0 = stall.
- Redirect_IN  input  1  taken branch/JAL/JALR resolved in EX.
- Target_IN  input  32  redirect target address.
- Instr_Mem_DATA  input  32  combinational read data from instruction memory.
- Instr_Mem_ADDR  output  32  equals the current PC.
- Instruction_OUT  output  32  to IF/ID. Equals Instr_Mem_DATA when Valid_OUT=1, otherwise NOP 32'h0000_0013.
- PC_OUT  output  32  PC of Instruction_OUT.
- PC4_OUT  output  32  PC_OUT + 4, modulo 2^32.
- Valid_OUT  output  1  Instruction_OUT is a real fetch.
- IF_ID_LE_OUT  output  1  load enable for IF/ID: LE & ~Redirect_IN.
- Flush_OUT  output  1  combinational; equals Redirect_IN. Drives the IF/ID Reset.
- Fetch_Count_OUT  output  32  number of instructions delivered.
- Misalign_OUT  output  1  sticky misaligned-target flag.

## Operation
- States: BOOT, RUN, STALL, plus TRAP when the macro is compiled in.
- Reset (any state, any inputs):
  - PC = RESET_PC; state = BOOT.
  - Fetch_Count_OUT = 0; Misalign_OUT = 0.
  - All outputs derived from these values; Valid_OUT = 0 while in BOOT.
- BOOT: exactly one cycle, PC held, no valid fetch. Next state is RUN.
- Per-cycle priority outside Reset: Redirect_IN > LE=0 > normal advance.
- Redirect_IN=1 (any non-BOOT state, regardless of LE):
  - PC <= Target_IN; state <= RUN.
  - Valid_OUT = 0 that cycle; the wrong-path word is not counted.
- LE=0 without redirect: PC held; state <= STALL; Valid_OUT = 0.
- RUN with LE=1: PC <= PC + 4 (wraps 32'hFFFF_FFFC -> 0); Valid_OUT = 1.
- STALL with LE=1: behaves as RUN (PC advances, Valid_OUT = 1); state <= RUN.
- Valid_OUT = (state in {RUN, STALL}) & LE & ~Redirect_IN.
- Fetch_Count_OUT increments by 1 on each edge where Valid_OUT=1; wraps from 2^32-1 to 0.
- Redirect arriving in the same cycle as the end of a stall: redirect wins; the stalled PC is discarded.

## Timing
- Instr_Mem_ADDR = PC with zero latency; the instruction memory read is combinational.
- Instruction_OUT, PC_OUT, PC4_OUT, Valid_OUT, Flush_OUT and IF_ID_LE_OUT are combinational within the cycle and are captured by IF/ID on the same edge.
- Redirect penalty:
  - Redirect asserted in cycle n: the IF/ID contents are flushed at edge n.
  - The target is fetched in cycle n+1; Valid_OUT=1 in n+1 if LE=1.
- After Reset deasserts: BOOT for 1 cycle, first valid fetch of RESET_PC in the next cycle.
- Reset in mid-stall or mid-redirect overrides everything at that edge.

## Configuration
- Macro IF_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with Target_IN[1:0] != 2'b00 sets Misalign_OUT (sticky until Reset).
  - PC <= TRAP_PC and state <= TRAP.
  - TRAP lasts one cycle with Valid_OUT = 0, then goes to RUN; TRAP_PC is fetched in the following cycle.
- Not defined:
  - Target_IN[1:0] is ignored (PC <= {Target_IN[31:2], 2'b00}).
  - Misalign_OUT is tied 0; no TRAP state exists.

## Structure
- Shared package rv_pipe_pkg:
  - fetch-state enum;
  - NOP constant 32'h0000_0013;
  - default RESET_PC and TRAP_PC constants.
- Sub-module pc_register: 32-bit register with synchronous Reset to RESET_PC, load enable and data input. The next-PC mux and the state machine remain in if_fetch_stage.

## Test plan
- Reset, then LE=1 for 4 cycles, memory returning 32'hA0+addr -> BOOT cycle, then PC 0,4,8,C; Valid_OUT=1 from cycle 2; Fetch_Count_OUT=3 after the third valid edge.
- At PC=8, LE=0 for 2 cycles -> PC held at 8, Valid_OUT=0, count frozen; LE=1 -> PC 8 delivered, then C.
- At PC=10, Redirect_IN=1, Target_IN=32'h40 -> Flush_OUT=1, IF_ID_LE_OUT=0, Valid_OUT=0; next cycle PC=40, Valid_OUT=1.
- Redirect_IN=1 with LE=0 simultaneously, Target_IN=32'h80 -> PC=80 next cycle; redirect overrides the stall.
- PC=32'hFFFF_FFFC with LE=1 -> PC4_OUT=0, next PC=0; Fetch_Count_OUT preloaded near 2^32-1 wraps to 0.
- Macro on: Target_IN=32'h42 -> Misalign_OUT=1, one TRAP cycle, then fetch at 32'h100; macro off: same stimulus -> PC=32'h40, Misalign_OUT=0.
